// File: rtl/cur_mb_fetch_pkg.sv
// Shared types and default geometry for the current-macroblock fetch path.
// Holds the FSM state encoding and the packed payload of one output word.
package cur_mb_fetch_pkg;

  localparam int unsigned DEF_FRAME_W = 3840;
  localparam int unsigned DEF_FRAME_H = 2160;
  localparam int unsigned DEF_BLK     = 16;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // One word of macroblock pixels plus its framing and position tags
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [IDX_W-1:0]  mb_x;
    logic [IDX_W-1:0]  mb_y;
  } mb_word_t;

endpackage

// File: rtl/cur_mb_fetch_addr_gen.sv
// Raster-order macroblock address generator: col/row/mb_x/mb_y counters with
// incremental row_base/mb_base tracking, so no multipliers are needed.
module cur_mb_fetch_addr_gen
  import cur_mb_fetch_pkg::*;
#(
  parameter int unsigned       FRAME_W   = DEF_FRAME_W,
  parameter int unsigned       FRAME_H   = DEF_FRAME_H,
  parameter int unsigned       BLK       = DEF_BLK,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  mb_x_o,
  output logic [IDX_W-1:0]  mb_y_o,
  output logic              first_word_of_mb_o,
  output logic              last_word_of_mb_o,
  output logic              last_word_of_frame_o
);

  localparam int unsigned       COLS   = BLK / 4;
  localparam int unsigned       MBS_X  = FRAME_W / BLK;
  localparam int unsigned       MBS_Y  = FRAME_H / BLK;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] MB_STEP  = ADDR_W'(BLK);

  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  mb_x_q, mb_x_d;
  logic [IDX_W-1:0]  mb_y_q, mb_y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] mb_base_q, mb_base_d;

  logic col_last, row_last, mbx_last, mby_last;

  assign col_last = (col_q  == IDX_W'(COLS - 1));
  assign row_last = (row_q  == IDX_W'(BLK - 1));
  assign mbx_last = (mb_x_q == IDX_W'(MBS_X - 1));
  assign mby_last = (mb_y_q == IDX_W'(MBS_Y - 1));

  // Next position; at the end of an MB row the next MB row starts exactly BLK
  // bytes past the last row_base (last row of the rightmost MB).
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    mb_x_d     = mb_x_q;
    mb_y_d     = mb_y_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    mb_base_d  = mb_base_q;
    if (clear_i) begin
      col_d      = '0;
      row_d      = '0;
      mb_x_d     = '0;
      mb_y_d     = '0;
      addr_d     = BASE_ADDR;
      row_base_d = BASE_ADDR;
      mb_base_d  = BASE_ADDR;
    end else if (advance_i) begin
      if (!col_last) begin
        col_d  = col_q + IDX_W'(1);
        addr_d = addr_q + ADDR_W'(4);
      end else begin
        col_d = '0;
        if (!row_last) begin
          row_d      = row_q + IDX_W'(1);
          row_base_d = row_base_q + ROW_STEP;
          addr_d     = row_base_d;
        end else begin
          row_d = '0;
          if (!mbx_last) begin
            mb_x_d     = mb_x_q + IDX_W'(1);
            mb_base_d  = mb_base_q + MB_STEP;
            row_base_d = mb_base_d;
            addr_d     = mb_base_d;
          end else begin
            mb_x_d = '0;
            if (!mby_last) begin
              mb_y_d     = mb_y_q + IDX_W'(1);
              mb_base_d  = row_base_q + MB_STEP;
              row_base_d = mb_base_d;
              addr_d     = mb_base_d;
            end else begin
              mb_y_d     = '0;
              mb_base_d  = BASE_ADDR;
              row_base_d = BASE_ADDR;
              addr_d     = BASE_ADDR;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      mb_x_q     <= '0;
      mb_y_q     <= '0;
      addr_q     <= BASE_ADDR;
      row_base_q <= BASE_ADDR;
      mb_base_q  <= BASE_ADDR;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      mb_x_q     <= mb_x_d;
      mb_y_q     <= mb_y_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      mb_base_q  <= mb_base_d;
    end
  end

  assign addr_o               = addr_q;
  assign mb_x_o               = mb_x_q;
  assign mb_y_o               = mb_y_q;
  assign first_word_of_mb_o   = (col_q == '0) && (row_q == '0);
  assign last_word_of_mb_o    = col_last && row_last;
  assign last_word_of_frame_o = col_last && row_last && mbx_last && mby_last;

endmodule

// File: rtl/cur_mb_fetch.sv
// Fetches a whole current frame from cur_mem, MB by MB in raster order, and
// streams it to the ME core as 32-bit words with sop/eop/frame_done framing.
module cur_mb_fetch
  import cur_mb_fetch_pkg::*;
#(
  parameter int unsigned       FRAME_W   = DEF_FRAME_W,
  parameter int unsigned       FRAME_H   = DEF_FRAME_H,
  parameter int unsigned       BLK       = DEF_BLK,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [IDX_W-1:0]  out_mb_x,
  output logic [IDX_W-1:0]  out_mb_y,
  output logic              frame_done
);

  fetch_state_e      state_q;
  mb_word_t          word_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              load;
  logic              gen_clear;
  logic [ADDR_W-1:0] gen_addr;
  logic [IDX_W-1:0]  gen_mb_x;
  logic [IDX_W-1:0]  gen_mb_y;
  logic              gen_first;
  logic              gen_last_mb;
  logic              gen_last_frame;

  // A word is read only when the output register is free or being emptied
  assign load      = (state_q == ST_FETCH) && (!valid_q || out_ready);
  assign gen_clear = (state_q == ST_IDLE) && start;

  cur_mb_fetch_addr_gen #(
    .FRAME_W   (FRAME_W),
    .FRAME_H   (FRAME_H),
    .BLK       (BLK),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clear_i              (gen_clear),
    .advance_i            (load),
    .addr_o               (gen_addr),
    .mb_x_o               (gen_mb_x),
    .mb_y_o               (gen_mb_y),
    .first_word_of_mb_o   (gen_first),
    .last_word_of_mb_o    (gen_last_mb),
    .last_word_of_frame_o (gen_last_frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        word_q.data <= mem_data;
        word_q.sop  <= gen_first;
        word_q.eop  <= gen_last_mb;
        word_q.mb_x <= gen_mb_x;
        word_q.mb_y <= gen_mb_y;
        valid_q     <= 1'b1;
        mem_addr_q  <= gen_addr;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (load && gen_last_frame) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            valid_q    <= 1'b0;
            word_q.sop <= 1'b0;
            word_q.eop <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Address is presented live on a read and held from the last read otherwise
  assign mem_en     = load;
  assign mem_addr   = load ? gen_addr : mem_addr_q;
  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign out_data   = word_q.data;
  assign out_sop    = word_q.sop;
  assign out_eop    = word_q.eop;
  assign out_mb_x   = word_q.mb_x;
  assign out_mb_y   = word_q.mb_y;
  assign frame_done = done_q;

endmodule
